// File: rtl/video_regs_pkg.sv
// Register map, reset values and decode helpers shared by the video register bank.
// Pure definitions: no state, no latency, no flow control.
package video_regs_pkg;

  localparam logic [7:0] A_BORDER  = 8'h00;
  localparam logic [7:0] A_ZBORDER = 8'h01;
  localparam logic [7:0] A_VPAGE   = 8'h02;
  localparam logic [7:0] A_ZVPAGE  = 8'h03;
  localparam logic [7:0] A_VCONF   = 8'h04;
  localparam logic [7:0] A_PALSEL  = 8'h05;
  localparam logic [7:0] A_TSCONF  = 8'h06;
  localparam logic [7:0] A_TMPAGE  = 8'h07;
  localparam logic [7:0] A_SGPAGE  = 8'h08;
  localparam logic [7:0] A_HINT    = 8'h09;
  localparam logic [7:0] A_VINT_L  = 8'h0A;
  localparam logic [7:0] A_VINT_H  = 8'h0B;
  localparam logic [7:0] A_CTRL    = 8'h0C;
  localparam logic [7:0] A_GX_L    = 8'h10;
  localparam logic [7:0] A_GX_H    = 8'h11;
  localparam logic [7:0] A_GY_L    = 8'h12;
  localparam logic [7:0] A_GY_H    = 8'h13;
  localparam logic [7:0] A_TX_BASE = 8'h20;
  localparam logic [7:0] A_TG_BASE = 8'h40;

  localparam logic [7:0] RST_VPAGE  = 8'h05;
  localparam logic [7:0] RST_PALSEL = 8'h0F;
  localparam logic [7:0] RST_HINT   = 8'h01;

  typedef enum logic {CLS_IMM, CLS_LINE} latch_cls_t;

  // Layer index for the 0x20..0x3F scroll block (4 regs per layer) or the 0x40.. page block.
  function automatic logic [2:0] addr_layer(input logic [7:0] a);
    return (a[7:5] == A_TX_BASE[7:5]) ? a[4:2] : a[2:0];
  endfunction

  function automatic latch_cls_t addr_class(input logic [7:0] a);
    if (a == A_VPAGE || a == A_VCONF || a == A_PALSEL || a == A_GX_H) return CLS_LINE;
    if (a[7:5] == A_TX_BASE[7:5] && a[1:0] == 2'd1) return CLS_LINE;
    if (a[7:3] == A_TG_BASE[7:3]) return CLS_LINE;
    return CLS_IMM;
  endfunction

endpackage

// File: rtl/video_vint_seq.sv
// Raster-interrupt line sequencer: vint_beg advances by inc modulo LINES on each int_start.
// Registered, 1-cycle update; never stalls, a same-cycle write takes priority over the step.
module video_vint_seq #(
  parameter int VINT_W = 9,
  parameter int LINES  = 320
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              i_wr_l,
  input  logic              i_wr_h,
  input  logic [7:0]        i_d,
  input  logic              i_int_start,
  output logic [VINT_W-1:0] o_vint_beg
);

  localparam logic [VINT_W:0] L_LINES = (VINT_W+1)'(LINES);

  logic [VINT_W-1:0] r_vint;
  logic [3:0]        r_inc;
  logic [VINT_W:0]   w_sum;
  logic [VINT_W:0]   w_wrap;

  assign w_sum  = {1'b0, r_vint} + {{(VINT_W-3){1'b0}}, r_inc};
  assign w_wrap = (w_sum >= L_LINES) ? (w_sum - L_LINES) : w_sum;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_vint <= '0;
      r_inc  <= '0;
    end else if (i_wr_l) begin
      r_vint[7:0] <= i_d;
    end else if (i_wr_h) begin
      r_vint[VINT_W-1:8] <= (VINT_W-8)'(i_d[0]);
      r_inc              <= i_d[7:4];
    end else if (i_int_start) begin
      r_vint <= w_wrap[VINT_W-1:0];
    end
  end

  assign o_vint_beg = r_vint;

endmodule

// File: rtl/video_regs_bank.sv
// Video register bank: port writes -> immediate regs (1 cycle) or line shadows copied on line_start_s.
// No backpressure; hold suppresses shadow transfer for tear-free multi-register updates.
module video_regs_bank
  import video_regs_pkg::*;
#(
  parameter int NLAYERS = 2,
  parameter int OFFS_W  = 9,
  parameter int VINT_W  = 9,
  parameter int LINES   = 320
) (
  input  logic                      clk,
  input  logic                      res_n,
  input  logic                      wr,
  input  logic [7:0]                addr,
  input  logic [7:0]                d,
  input  logic                      line_start_s,
  input  logic                      int_start,
  output logic [7:0]                border,
  output logic [7:0]                vpage,
  output logic [7:0]                vconf,
  output logic [7:0]                palsel,
  output logic [7:0]                tsconf,
  output logic [7:0]                tmpage,
  output logic [7:0]                sgpage,
  output logic [7:0]                hint_beg,
  output logic [OFFS_W-1:0]         gx_offs,
  output logic [OFFS_W-1:0]         gy_offs,
  output logic [NLAYERS*OFFS_W-1:0] tx_offs,
  output logic [NLAYERS*OFFS_W-1:0] ty_offs,
  output logic [NLAYERS*8-1:0]      tgpage,
  output logic [VINT_W-1:0]         vint_beg,
  output logic                      upd_pend
);

  localparam logic [3:0] NL = 4'(NLAYERS);

  logic [7:0]        r_border, r_tsconf, r_tmpage, r_sgpage, r_hint;
  logic [OFFS_W-1:0] r_gy;
  logic [OFFS_W-1:0] r_ty [NLAYERS];
  logic [7:0]        r_stage;
  logic              r_hold;
  logic              r_pend;

  logic [7:0]        r_vpage_sh, r_vconf_sh, r_palsel_sh;
  logic [OFFS_W-1:0] r_gx_sh;
  logic [OFFS_W-1:0] r_tx_sh [NLAYERS];
  logic [7:0]        r_tg_sh [NLAYERS];

  logic [7:0]        r_vpage, r_vconf, r_palsel;
  logic [OFFS_W-1:0] r_gx;
  logic [OFFS_W-1:0] r_tx [NLAYERS];
  logic [7:0]        r_tg [NLAYERS];

  logic [2:0]        w_layer;
  logic              w_layer_ok, w_lay_wr, w_tg_wr, w_line_wr, w_xfer, w_zv;
  logic [7:0]        w_zv_val;
  logic [OFFS_W-1:0] w_commit;

  assign w_layer    = addr_layer(addr);
  assign w_layer_ok = ({1'b0, w_layer} < NL);
  assign w_lay_wr   = wr && (addr[7:5] == A_TX_BASE[7:5]) && w_layer_ok;
  assign w_tg_wr    = wr && (addr[7:3] == A_TG_BASE[7:3]) && w_layer_ok;
  assign w_line_wr  = (addr_class(addr) == CLS_LINE) &&
                      (w_lay_wr || w_tg_wr || (wr && addr[7:5] == 3'b000));
  assign w_xfer     = line_start_s && !r_hold;
  assign w_zv       = wr && (addr == A_ZVPAGE);
  assign w_zv_val   = {6'b000001, d[3], 1'b1};
  // High byte pairs with the retained stage byte so a high-only write reuses the last low.
  assign w_commit   = {d[OFFS_W-9:0], r_stage};

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_border <= '0;
      r_tsconf <= '0;
      r_tmpage <= '0;
      r_sgpage <= '0;
      r_hint   <= RST_HINT;
      r_gy     <= '0;
      r_stage  <= '0;
      r_hold   <= 1'b0;
      for (int i = 0; i < NLAYERS; i++) r_ty[i] <= '0;
    end else if (wr) begin
      case (addr)
        A_BORDER:  r_border <= d;
        A_ZBORDER: r_border <= {5'b11110, d[2:0]};
        A_TSCONF:  r_tsconf <= d;
        A_TMPAGE:  r_tmpage <= d;
        A_SGPAGE:  r_sgpage <= d;
        A_HINT:    r_hint   <= d;
        A_CTRL:    r_hold   <= d[0];
        A_GY_H:    r_gy     <= w_commit;
        default:   ;
      endcase
      if (addr == A_GX_L || addr == A_GY_L || (w_lay_wr && !addr[0])) r_stage <= d;
      for (int i = 0; i < NLAYERS; i++) begin
        if (w_lay_wr && w_layer == 3'(i) && addr[1:0] == 2'd3) r_ty[i] <= w_commit;
      end
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_vpage_sh  <= RST_VPAGE;
      r_vconf_sh  <= '0;
      r_palsel_sh <= RST_PALSEL;
      r_gx_sh     <= '0;
      for (int i = 0; i < NLAYERS; i++) begin
        r_tx_sh[i] <= '0;
        r_tg_sh[i] <= '0;
      end
    end else if (wr) begin
      case (addr)
        A_VPAGE:  r_vpage_sh  <= d;
        A_ZVPAGE: r_vpage_sh  <= w_zv_val;
        A_VCONF:  r_vconf_sh  <= d;
        A_PALSEL: r_palsel_sh <= d;
        A_GX_H:   r_gx_sh     <= w_commit;
        default:  ;
      endcase
      for (int i = 0; i < NLAYERS; i++) begin
        if (w_lay_wr && w_layer == 3'(i) && addr[1:0] == 2'd1) r_tx_sh[i] <= w_commit;
        if (w_tg_wr && w_layer == 3'(i)) r_tg_sh[i] <= d;
      end
    end
  end

  // Transfer samples the pre-write shadows; zvpage overrides the transferred vpage.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_vpage  <= RST_VPAGE;
      r_vconf  <= '0;
      r_palsel <= RST_PALSEL;
      r_gx     <= '0;
      for (int i = 0; i < NLAYERS; i++) begin
        r_tx[i] <= '0;
        r_tg[i] <= '0;
      end
    end else begin
      if (w_xfer) begin
        r_vpage  <= r_vpage_sh;
        r_vconf  <= r_vconf_sh;
        r_palsel <= r_palsel_sh;
        r_gx     <= r_gx_sh;
        for (int i = 0; i < NLAYERS; i++) begin
          r_tx[i] <= r_tx_sh[i];
          r_tg[i] <= r_tg_sh[i];
        end
      end
      if (w_zv) r_vpage <= w_zv_val;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n)         r_pend <= 1'b0;
    else if (w_line_wr) r_pend <= 1'b1;
    else if (w_xfer)    r_pend <= 1'b0;
  end

  video_vint_seq #(
    .VINT_W (VINT_W),
    .LINES  (LINES)
  ) u_vint (
    .clk         (clk),
    .res_n       (res_n),
    .i_wr_l      (wr && addr == A_VINT_L),
    .i_wr_h      (wr && addr == A_VINT_H),
    .i_d         (d),
    .i_int_start (int_start),
    .o_vint_beg  (vint_beg)
  );

  for (genvar g = 0; g < NLAYERS; g++) begin : g_lay
    assign tx_offs[g*OFFS_W +: OFFS_W] = r_tx[g];
    assign ty_offs[g*OFFS_W +: OFFS_W] = r_ty[g];
    assign tgpage[g*8 +: 8]            = r_tg[g];
  end

  assign border   = r_border;
  assign vpage    = r_vpage;
  assign vconf    = r_vconf;
  assign palsel   = r_palsel;
  assign tsconf   = r_tsconf;
  assign tmpage   = r_tmpage;
  assign sgpage   = r_sgpage;
  assign hint_beg = r_hint;
  assign gx_offs  = r_gx;
  assign gy_offs  = r_gy;
  assign upd_pend = r_pend;

endmodule

// File: tb/tb_video_regs_bank.sv
// Directed bench for video_regs_bank with default parameters (2 layers, 9-bit offsets, 320 lines).
module tb_video_regs_bank;

  logic        clk = 1'b0;
  logic        res_n;
  logic        wr;
  logic [7:0]  addr;
  logic [7:0]  d;
  logic        line_start_s;
  logic        int_start;
  logic [7:0]  border, vpage, vconf, palsel, tsconf, tmpage, sgpage, hint_beg;
  logic [8:0]  gx_offs, gy_offs;
  logic [17:0] tx_offs, ty_offs;
  logic [15:0] tgpage;
  logic [8:0]  vint_beg;
  logic        upd_pend;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  video_regs_bank #(.NLAYERS(2), .OFFS_W(9), .VINT_W(9), .LINES(320)) dut (
    .clk          (clk),
    .res_n        (res_n),
    .wr           (wr),
    .addr         (addr),
    .d            (d),
    .line_start_s (line_start_s),
    .int_start    (int_start),
    .border       (border),
    .vpage        (vpage),
    .vconf        (vconf),
    .palsel       (palsel),
    .tsconf       (tsconf),
    .tmpage       (tmpage),
    .sgpage       (sgpage),
    .hint_beg     (hint_beg),
    .gx_offs      (gx_offs),
    .gy_offs      (gy_offs),
    .tx_offs      (tx_offs),
    .ty_offs      (ty_offs),
    .tgpage       (tgpage),
    .vint_beg     (vint_beg),
    .upd_pend     (upd_pend)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] v);
    wr = 1'b1; addr = a; d = v;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic wr_ls(input logic [7:0] a, input logic [7:0] v);
    wr = 1'b1; addr = a; d = v; line_start_s = 1'b1;
    @(negedge clk);
    wr = 1'b0; line_start_s = 1'b0;
  endtask

  task automatic wr_int(input logic [7:0] a, input logic [7:0] v);
    wr = 1'b1; addr = a; d = v; int_start = 1'b1;
    @(negedge clk);
    wr = 1'b0; int_start = 1'b0;
  endtask

  task automatic pulse_ls();
    line_start_s = 1'b1;
    @(negedge clk);
    line_start_s = 1'b0;
  endtask

  task automatic pulse_int();
    int_start = 1'b1;
    @(negedge clk);
    int_start = 1'b0;
  endtask

  initial begin
    res_n = 1'b0; wr = 1'b0; addr = '0; d = '0; line_start_s = 1'b0; int_start = 1'b0;
    cyc(); cyc();
    chk("rst_vpage", 32'(vpage), 32'h05);
    chk("rst_palsel", 32'(palsel), 32'h0F);
    chk("rst_hint", 32'(hint_beg), 32'h01);
    chk("rst_border", 32'(border), 32'h00);
    chk("rst_vconf", 32'(vconf), 32'h00);
    chk("rst_misc8", 32'({tsconf, tmpage, sgpage}), 32'h0);
    chk("rst_offs", 32'({gx_offs, gy_offs}), 32'h0);
    chk("rst_layers", 32'({tx_offs, ty_offs} != 36'd0), 32'h0);
    chk("rst_tgpage", 32'(tgpage), 32'h0);
    chk("rst_vint", 32'(vint_beg), 32'h0);
    chk("rst_pend", 32'(upd_pend), 32'h0);
    res_n = 1'b1;
    cyc();

    // Line-class write then delayed line start
    wr_reg(8'h04, 8'h81);
    chk("vconf_pre", 32'(vconf), 32'h00);
    chk("pend_set", 32'(upd_pend), 32'h1);
    cyc(); cyc();
    chk("vconf_wait", 32'(vconf), 32'h00);
    pulse_ls();
    chk("vconf_xfer", 32'(vconf), 32'h81);
    chk("pend_clr", 32'(upd_pend), 32'h0);
    chk("vpage_keep", 32'(vpage), 32'h05);

    // Immediate class
    wr_reg(8'h00, 8'h55);
    chk("border", 32'(border), 32'h55);
    wr_reg(8'h01, 8'hFF);
    chk("zborder", 32'(border), 32'hF7);
    wr_reg(8'h06, 8'hA5);
    chk("tsconf", 32'(tsconf), 32'hA5);
    wr_reg(8'h09, 8'h20);
    chk("hint", 32'(hint_beg), 32'h20);
    chk("imm_no_pend", 32'(upd_pend), 32'h0);

    // Layer 1 tx pair split across a line start
    wr_reg(8'h24, 8'h34);
    chk("txl_no_pend", 32'(upd_pend), 32'h0);
    pulse_ls();
    chk("tx_after_l", 32'(tx_offs), 32'h0);
    wr_reg(8'h25, 8'h01);
    chk("tx_h_pend", 32'(upd_pend), 32'h1);
    chk("tx_h_shadow", 32'(tx_offs), 32'h0);
    pulse_ls();
    chk("tx_xfer", 32'(tx_offs), 32'h26800);

    // High-only write reuses retained stage byte
    wr_reg(8'h13, 8'h01);
    chk("gy_stage", 32'(gy_offs), 32'h134);
    wr_reg(8'h22, 8'hAB);
    wr_reg(8'h23, 8'h00);
    chk("ty0", 32'(ty_offs), 32'h000AB);
    wr_reg(8'h2C, 8'h77);
    wr_reg(8'h27, 8'h01);
    chk("ty1_ign_l3", 32'(ty_offs), 32'h356AB);

    wr_reg(8'h41, 8'h9C);
    wr_reg(8'h42, 8'h11);
    chk("tg_pend", 32'(upd_pend), 32'h1);
    chk("tg_shadow", 32'(tgpage), 32'h0);
    pulse_ls();
    chk("tg_xfer", 32'(tgpage), 32'h9C00);

    // Hold / commit
    wr_reg(8'h0C, 8'h01);
    wr_reg(8'h02, 8'h20);
    pulse_ls();
    cyc();
    pulse_ls();
    chk("hold_vpage", 32'(vpage), 32'h05);
    chk("hold_pend", 32'(upd_pend), 32'h1);
    wr_reg(8'h0C, 8'h00);
    chk("unhold_wait", 32'(vpage), 32'h05);
    pulse_ls();
    chk("unhold_vpage", 32'(vpage), 32'h20);
    chk("unhold_pend", 32'(upd_pend), 32'h0);

    // Write coincident with line start
    wr_ls(8'h04, 8'h42);
    chk("coinc_vconf", 32'(vconf), 32'h81);
    chk("coinc_pend", 32'(upd_pend), 32'h1);
    pulse_ls();
    chk("coinc_next", 32'(vconf), 32'h42);

    // zvpage wins over transfer
    wr_reg(8'h02, 8'h40);
    wr_ls(8'h03, 8'h08);
    chk("zvpage", 32'(vpage), 32'h07);
    chk("zv_pend", 32'(upd_pend), 32'h0);
    pulse_ls();
    chk("zv_shadow", 32'(vpage), 32'h07);

    // vint sequencer
    wr_reg(8'h0A, 8'h3F);
    wr_reg(8'h0B, 8'hF1);
    chk("vint_wr", 32'(vint_beg), 32'h13F);
    pulse_int();
    chk("vint_wrap15", 32'(vint_beg), 32'h00E);
    wr_int(8'h0A, 8'h00);
    chk("vint_wr_wins", 32'(vint_beg), 32'h000);
    pulse_int();
    chk("vint_step", 32'(vint_beg), 32'h00F);
    wr_reg(8'h0A, 8'h3E);
    wr_reg(8'h0B, 8'hF1);
    pulse_int();
    chk("vint_318_15", 32'(vint_beg), 32'h00D);
    wr_reg(8'h0B, 8'h01);
    pulse_int();
    chk("vint_inc0", 32'(vint_beg), 32'h10D);
    wr_reg(8'h0A, 8'h3F);
    wr_reg(8'h0B, 8'h11);
    pulse_int();
    chk("vint_319_1", 32'(vint_beg), 32'h000);

    // Mid-frame reset
    wr_reg(8'h04, 8'h99);
    #2 res_n = 1'b0;
    #1;
    chk("mrst_vconf", 32'(vconf), 32'h00);
    chk("mrst_border", 32'(border), 32'h00);
    chk("mrst_vpage", 32'(vpage), 32'h05);
    chk("mrst_pend", 32'(upd_pend), 32'h0);
    chk("mrst_vint", 32'(vint_beg), 32'h0);
    @(negedge clk);
    res_n = 1'b1;
    cyc();
    pulse_ls();
    chk("post_rst_vconf", 32'(vconf), 32'h00);
    chk("post_rst_tg", 32'(tgpage), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
